// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the multi-read-port register file.
//   rf_state_t : CLEAR (zeroing the array after reset) / RUN (normal operation)
//   RF_XLEN, RF_NREGS, RF_NRD : default parameter values for regfile_mp
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_NRD   = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Pending-write scoreboard: one bit per register, set when a producer is
// issued, cleared when its result is written back.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset (clears all bits)
//   i_set_en/i_set_addr   mark a register pending
//   i_clr_en/i_clr_addr   mark a register resolved
//   i_lookup_addr         NRD packed lookup addresses
//   o_lookup_busy         NRD pending bits, combinational from registered state
// Set beats clear on the same address: the newer producer is still outstanding.
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_set_en,
    input  logic [$clog2(NREGS)-1:0]       i_set_addr,
    input  logic                           i_clr_en,
    input  logic [$clog2(NREGS)-1:0]       i_clr_addr,
    input  logic [NRD*$clog2(NREGS)-1:0]   i_lookup_addr,
    output logic [NRD-1:0]                 o_lookup_busy
);
    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0] pending_reg;
    logic [NREGS-1:0] pending_next;

    always_comb begin
        pending_next = pending_reg;
        if (i_clr_en) begin
            pending_next[i_clr_addr] = 1'b0;
        end
        // Applied after the clear so that it takes priority.
        if (i_set_en) begin
            pending_next[i_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_lookup
            assign o_lookup_busy[gi] = pending_reg[i_lookup_addr[gi*AW +: AW]];
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised NRD-read / 1-write integer register file with pending-write
// scoreboard and a self-clearing sequence after reset.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   o_ready                      high once every register has been zeroed
//   i_rd_en/i_rd_addr/i_rd_data  write port (clears the pending bit)
//   i_alloc_en/i_alloc_addr      mark a register pending (producer issued)
//   i_rs_addr                    NRD packed read addresses
//   o_rs_data/o_rs_busy          NRD read data and pending bits, combinational
//   d_regs_out                   debug view of the whole array
// Optional build macro REGFILE_BYPASS_EN: a read of the address being written
// this cycle returns the write data, with busy taken from a same-cycle alloc.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NREGS    = RF_NREGS,
    parameter int NRD      = RF_NRD,
    parameter int ZERO_REG = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    output logic                          o_ready,
    input  logic                          i_rd_en,
    input  logic [$clog2(NREGS)-1:0]      i_rd_addr,
    input  logic [XLEN-1:0]               i_rd_data,
    input  logic                          i_alloc_en,
    input  logic [$clog2(NREGS)-1:0]      i_alloc_addr,
    input  logic [NRD*$clog2(NREGS)-1:0]  i_rs_addr,
    output logic [NRD*XLEN-1:0]           o_rs_data,
    output logic [NRD-1:0]                o_rs_busy,
    output logic [NREGS*XLEN-1:0]         d_regs_out
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_t       state_reg;
    logic [AW-1:0]   idx_reg;
    logic            ready_reg;
    logic [XLEN-1:0] regs_reg [NREGS];

    logic            run_active;
    logic            wr_eff;
    logic            alloc_eff;
    logic [NRD-1:0]  sb_busy;

    // Outputs are forced quiet while reset is asserted, not only from the
    // edge after it, so the read ports never leak stale contents under reset.
    assign run_active = (state_reg == RF_RUN) && !i_rst;
    assign wr_eff     = run_active && i_rd_en
                        && !((ZERO_REG != 0) && (i_rd_addr == '0));
    assign alloc_eff  = run_active && i_alloc_en
                        && !((ZERO_REG != 0) && (i_alloc_addr == '0));
    assign o_ready    = ready_reg;

    // Clear sequencer: one register zeroed per edge, then RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= RF_CLEAR;
            idx_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                RF_CLEAR: begin
                    idx_reg <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= RF_RUN;
                        ready_reg <= 1'b1;
                    end
                end
                RF_RUN: begin
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= RF_CLEAR;
                    idx_reg   <= '0;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset: contents are established by the clear sequence.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state_reg == RF_CLEAR) begin
                regs_reg[idx_reg] <= '0;
            end else if (wr_eff) begin
                regs_reg[i_rd_addr] <= i_rd_data;
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_set_en      (alloc_eff),
        .i_set_addr    (i_alloc_addr),
        .i_clr_en      (wr_eff),
        .i_clr_addr    (i_rd_addr),
        .i_lookup_addr (i_rs_addr),
        .o_lookup_busy (sb_busy)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_read
            logic [AW-1:0] ra;
            logic          zero_hit;
            assign ra       = i_rs_addr[gi*AW +: AW];
            assign zero_hit = (ZERO_REG != 0) && (ra == '0);
`ifdef REGFILE_BYPASS_EN
            logic byp_hit;
            // wr_eff already excludes hardwired-zero writes, so they never forward.
            assign byp_hit = wr_eff && (ra == i_rd_addr);
            assign o_rs_data[gi*XLEN +: XLEN] =
                (!run_active || zero_hit) ? '0 :
                byp_hit                   ? i_rd_data :
                                            regs_reg[ra];
            assign o_rs_busy[gi] =
                !run_active ? 1'b0 :
                byp_hit     ? (alloc_eff && (i_alloc_addr == ra)) :
                              sb_busy[gi];
`else
            assign o_rs_data[gi*XLEN +: XLEN] =
                (!run_active || zero_hit) ? '0 : regs_reg[ra];
            assign o_rs_busy[gi] = run_active && sb_busy[gi];
`endif
        end

        for (gi = 0; gi < NREGS; gi++) begin : g_debug
            assign d_regs_out[gi*XLEN +: XLEN] = regs_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Self-checking bench for regfile_mp (default parameters, ZERO_REG=1).
// Holds a transaction-level model of the register file: an array of values,
// an array of pending flags and a count of clearing edges since reset.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int XLEN  = RF_XLEN;
    localparam int NREGS = RF_NREGS;
    localparam int NRD   = RF_NRD;
    localparam int AW    = $clog2(NREGS);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ready;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic [XLEN-1:0]      rd_data;
    logic                 alloc_en;
    logic [AW-1:0]        alloc_addr;
    logic [NRD*AW-1:0]    rs_addr;
    logic [NRD*XLEN-1:0]  rs_data;
    logic [NRD-1:0]       rs_busy;
    logic [NREGS*XLEN-1:0] dregs;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_ready      (ready),
        .i_rd_en      (rd_en),
        .i_rd_addr    (rd_addr),
        .i_rd_data    (rd_data),
        .i_alloc_en   (alloc_en),
        .i_alloc_addr (alloc_addr),
        .i_rs_addr    (rs_addr),
        .o_rs_data    (rs_data),
        .o_rs_busy    (rs_busy),
        .d_regs_out   (dregs)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];
    bit              m_ready = 1'b0;
    int              m_cleared = 0;

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_edge();
        if (rst) begin
            m_ready   = 1'b0;
            m_cleared = 0;
            for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
        end else if (!m_ready) begin
            m_regs[m_cleared] = '0;
            m_cleared++;
            if (m_cleared == NREGS) m_ready = 1'b1;
        end else begin
            if (rd_en && rd_addr != 0) begin
                m_regs[rd_addr] = rd_data;
                m_pend[rd_addr] = 1'b0;
            end
            if (alloc_en && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
        end
    endfunction

    function automatic logic [XLEN-1:0] exp_data(int a);
        if (rst || !m_ready || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (rd_en && int'(rd_addr) == a) return rd_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(int a);
        if (rst || !m_ready || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (rd_en && int'(rd_addr) == a) return alloc_en && int'(alloc_addr) == a;
`endif
        return m_pend[a];
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_en = 1'b0; rd_addr = '0; rd_data = '0;
        alloc_en = 1'b0; alloc_addr = '0;
    endtask

    task automatic set_reads(int a0, int a1);
        rs_addr[0 +: AW]  = AW'(a0);
        rs_addr[AW +: AW] = AW'(a1);
    endtask

    task automatic test_reset();
        idle_inputs();
        set_reads(5, 9);
        rst = 1'b1;
        repeat (3) tick();
        #1;
        n_tests++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_tests++;
        if (rs_data !== '0 || rs_busy !== '0) begin
            n_fail++; $display("FAIL reset_outputs: data %h busy %b want 0", rs_data, rs_busy);
        end
        rst = 1'b0;
        for (int c = 0; c < NREGS; c++) begin
            // Write/alloc requests during CLEAR must be ignored.
            rd_en = 1'($urandom_range(0, 1)); rd_addr = AW'($urandom);
            rd_data = $urandom; alloc_en = 1'($urandom_range(0, 1));
            alloc_addr = AW'($urandom);
            set_reads(int'($urandom_range(0, NREGS-1)), int'($urandom_range(0, NREGS-1)));
            #1;
            n_tests++;
            if (ready !== 1'b0 || rs_data !== '0 || rs_busy !== '0) begin
                n_fail++;
                $display("FAIL clear_cycle%0d: ready %b data %h busy %b want 0", c, ready, rs_data, rs_busy);
            end
            tick();
        end
        idle_inputs();
        n_tests++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_clear: got %b want 1", ready); end
        for (int i = 0; i < NREGS; i++) begin
            n_tests++;
            if (dregs[i*XLEN +: XLEN] !== '0) begin
                n_fail++; $display("FAIL cleared_x%0d: got %h want 0", i, dregs[i*XLEN +: XLEN]);
            end
        end
        $display("[TB] reset/clear sequence done");
    endtask

    task automatic test_write_read();
        idle_inputs();
        rd_en = 1'b1; rd_addr = 5; rd_data = 32'hDEADBEEF;
        set_reads(1, 2);
        tick();
        idle_inputs();
        set_reads(5, 5);
        #1;
        for (int k = 0; k < NRD; k++) begin
            n_tests++;
            if (rs_data[k*XLEN +: XLEN] !== 32'hDEADBEEF || rs_busy[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL write_read port%0d: data %h busy %b want deadbeef 0", k, rs_data[k*XLEN +: XLEN], rs_busy[k]);
            end
        end
        $display("[TB] write x5 read back");
    endtask

    task automatic test_alloc_hold();
        idle_inputs();
        alloc_en = 1'b1; alloc_addr = 7;
        set_reads(7, 7);
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (rs_busy !== 2'b11) begin
                n_fail++; $display("FAIL alloc_hold cycle%0d: busy %b want 11", c, rs_busy);
            end
            tick();
        end
        rd_en = 1'b1; rd_addr = 7; rd_data = 32'h1234;
        set_reads(3, 4);
        tick();
        idle_inputs();
        set_reads(7, 7);
        #1;
        n_tests++;
        if (rs_busy !== 2'b00 || rs_data !== {32'h1234, 32'h1234}) begin
            n_fail++; $display("FAIL alloc_release: data %h busy %b want 00001234x2 00", rs_data, rs_busy);
        end
        $display("[TB] alloc x7 held then written");
    endtask

    task automatic test_alloc_write_same();
        idle_inputs();
        rd_en = 1'b1; rd_addr = 9; rd_data = 32'h55;
        alloc_en = 1'b1; alloc_addr = 9;
        tick();
        idle_inputs();
        set_reads(9, 9);
        #1;
        n_tests++;
        if (rs_data[XLEN-1:0] !== 32'h55 || rs_busy !== 2'b11) begin
            n_fail++; $display("FAIL alloc_write_same: data %h busy %b want 55 11", rs_data[XLEN-1:0], rs_busy);
        end
        $display("[TB] alloc+write x9 same edge");
    endtask

    task automatic test_zero_and_bypass();
        idle_inputs();
        rd_en = 1'b1; rd_addr = 0; rd_data = 32'hFFFFFFFF;
        alloc_en = 1'b1; alloc_addr = 0;
        set_reads(0, 0);
        #1;
        n_tests++;
        if (rs_data !== '0 || rs_busy !== '0) begin
            n_fail++; $display("FAIL x0_same_cycle: data %h busy %b want 0", rs_data, rs_busy);
        end
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (rs_data !== '0 || rs_busy !== '0 || dregs[XLEN-1:0] !== '0) begin
            n_fail++; $display("FAIL x0_after: data %h busy %b arr %h want 0", rs_data, rs_busy, dregs[XLEN-1:0]);
        end
        rd_en = 1'b1; rd_addr = 3; rd_data = 32'h11;
        tick();
        rd_data = 32'hA5;
        set_reads(3, 3);
        #1;
        for (int k = 0; k < NRD; k++) begin
            logic [XLEN-1:0] want;
`ifdef REGFILE_BYPASS_EN
            want = 32'hA5;
`else
            want = 32'h11;
`endif
            n_tests++;
            if (rs_data[k*XLEN +: XLEN] !== want || rs_busy[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL bypass_x3 port%0d: data %h busy %b want %h 0", k, rs_data[k*XLEN +: XLEN], rs_busy[k], want);
            end
        end
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (rs_data[XLEN-1:0] !== 32'hA5) begin
            n_fail++; $display("FAIL x3_after: data %h want a5", rs_data[XLEN-1:0]);
        end
        $display("[TB] x0 hardwired zero and same-cycle read of x3");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            // Narrow address range most of the time so writes, allocs and reads collide.
            int hi;
            hi = ($urandom_range(0, 3) == 0) ? NREGS-1 : 7;
            rd_en      = 1'($urandom_range(0, 1));
            rd_addr    = AW'($urandom_range(0, hi));
            rd_data    = $urandom;
            alloc_en   = 1'($urandom_range(0, 2) == 0);
            alloc_addr = AW'($urandom_range(0, hi));
            set_reads(int'($urandom_range(0, hi)), int'($urandom_range(0, hi)));
            #1;
            for (int k = 0; k < NRD; k++) begin
                int a;
                a = int'(rs_addr[k*AW +: AW]);
                n_tests++;
                if (rs_data[k*XLEN +: XLEN] !== exp_data(a) || rs_busy[k] !== exp_busy(a)) begin
                    n_fail++;
                    $display("FAIL random c%0d port%0d x%0d: data %h busy %b want %h %b",
                             c, k, a, rs_data[k*XLEN +: XLEN], rs_busy[k], exp_data(a), exp_busy(a));
                end
            end
            n_tests++;
            if (ready !== m_ready) begin n_fail++; $display("FAIL random_ready c%0d: got %b want %b", c, ready, m_ready); end
            tick();
        end
        idle_inputs();
        $display("[TB] randomized write/alloc/read traffic done");
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 100) begin
            set_reads(int'($urandom_range(1, NREGS-1)), int'($urandom_range(1, NREGS-1)));
            tick();
            cnt++;
        end
        n_tests++;
        if (cnt != NREGS) begin n_fail++; $display("FAIL restart_latency: got %0d edges want %0d", cnt, NREGS); end
        for (int i = 0; i < NREGS; i++) begin
            n_tests++;
            if (dregs[i*XLEN +: XLEN] !== '0) begin
                n_fail++; $display("FAIL recleared_x%0d: got %h want 0", i, dregs[i*XLEN +: XLEN]);
            end
        end
        set_reads(3, 9);
        #1;
        n_tests++;
        if (rs_data !== '0 || rs_busy !== '0) begin
            n_fail++; $display("FAIL after_restart: data %h busy %b want 0", rs_data, rs_busy);
        end
        $display("[TB] reset during clear restarts sequence");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        rs_addr = '0;
        test_reset();
        test_write_read();
        test_alloc_hold();
        test_alloc_write_same();
        test_zero_and_bypass();
        test_random();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file with a pending-write scoreboard, self-clearing reset sequence and optional write-to-read bypass. It sits in the execute stage in place of the fixed 2R1W file. Decode uses the scoreboard outputs for hazard stalls. The clear sequence guarantees every architectural register reads zero after reset, with no reliance on memory initialisation.

## Interface
- XLEN, 32: register data width.
- NREGS, 32: register count, power of two, ≥ 2; AW = $clog2(NREGS).
- NRD, 2: number of read ports, ≥ 1.
- ZERO_REG, 1: when 1, register 0 is hardwired zero.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- o_ready  out  1  high once the clear sequence is done; 0 during reset and clear.
- i_rd_en  in  1  write enable.
- i_rd_addr  in  AW  write address.
- i_rd_data  in  XLEN  write data.
- i_alloc_en  in  1  mark the register as pending (producer issued).
- i_alloc_addr  in  AW  register to mark pending.
- i_rs_addr  in  NRD×AW  read addresses.
- o_rs_data  out  NRD×XLEN  read data, combinational.
- o_rs_busy  out  NRD  pending bit of the addressed register, combinational.
- d_regs_out  out  NREGS×XLEN  debug view of the array.

## Operation
- States: CLEAR and RUN.
  - Reset forces state=CLEAR, clear index idx=0, all pending bits=0.
- CLEAR:
  - Each edge with i_rst low writes 0 to register idx, then idx increments.
  - On the edge that clears idx=NREGS-1, state→RUN.
  - i_rd_en and i_alloc_en are ignored.
  - o_rs_data and o_rs_busy read 0.
- RUN:
  - When i_rd_en is high, the edge writes i_rd_data to i_rd_addr and clears that register's pending bit.
  - When i_alloc_en is high, the edge sets the pending bit of i_alloc_addr.
  - Alloc and write to the same address on the same edge: the data is written and the pending bit ends at 1. Alloc wins, because a newer producer is outstanding.
- ZERO_REG=1: register 0 is never written, always reads 0 and is never busy. Alloc or write to address 0 is ignored. CLEAR still visits idx 0.
- Reads: o_rs_data[k] = registers[i_rs_addr[k]]; o_rs_busy[k] = pending[i_rs_addr[k]].
  - Any number of ports may read the same address.
- Reset mid-CLEAR or mid-RUN: the state returns to CLEAR with idx=0 and the full sequence restarts. Register contents are not preserved.

## Timing
- Output values under reset: o_ready=0, o_rs_data=0, o_rs_busy=0.
- d_regs_out shows array contents, which are undefined until cleared.
- o_ready rises after exactly NREGS edges with i_rst low following reset deassertion.
  - It is registered and glitch-free.
- Write latency:
  - Without bypass, data is visible on the read ports in the cycle after the write edge.
  - The busy bit drops in that same following cycle.
- Alloc latency: o_rs_busy rises in the cycle after the alloc edge.
- No backpressure. Callers must not issue alloc or write while o_ready=0.

## Configuration
- REGFILE_BYPASS_EN, when defined: any read port whose address equals i_rd_addr while i_rd_en=1 in RUN returns i_rd_data in the same cycle. Its o_rs_busy reads 0 unless i_alloc_en targets the same address.
  - Writes to register 0 under ZERO_REG=1 are never forwarded.
- Undefined: reads return the pre-write array contents, and busy reflects registered state only.

## Structure
- Package regfile_pkg holds:
  - the state enum rf_state_t {RF_CLEAR, RF_RUN};
  - default parameter constants RF_XLEN, RF_NREGS, RF_NRD.
- One sub-module, regfile_scoreboard, holds the NREGS pending-bit vector with set, clear and reset logic and exposes NRD lookups.
- The array, CLEAR FSM and bypass muxing live in regfile_mp.

## Test plan
- Reset then release; hold i_rst low for 32 cycles (defaults) -> o_ready rises on cycle 32. Every d_regs_out entry is 0, and o_rs_data reads 0 throughout.
- After o_ready, write 0xDEADBEEF to x5 and read x5 on both ports next cycle -> both read 0xDEADBEEF. Busy is 0.
- Alloc x7, then hold; write x7=0x1234 three cycles later -> o_rs_busy=1 for those cycles, then 0 with data 0x1234.
- Alloc x9 and write x9=0x55 on the same edge -> data reads 0x55 and busy stays 1.
- Write x0=0xFFFFFFFF plus alloc x0 -> x0 reads 0 and is not busy. Bypass build: the same-cycle read of x3 during a write of x3=0xA5 returns 0xA5; the non-bypass build returns the old value.
- Assert i_rst at clear idx 10, release -> o_ready is delayed to 32 cycles after release, and all registers read 0.
